float_to_fixed: RTL and testbench

//  Pipelined IEEE-754 binary32 -> signed fixed-point converter with valid/ready handshake.

---
 rtl/fp_pkg.sv | 34 +++
 rtl/float_to_fixed_round_sat.sv | 86 ++++++++
 rtl/float_to_fixed.sv | 139 +++++++++++++
 tb/tb_float_to_fixed.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the float<->fixed conversion stages.
package fp_pkg;

    localparam int unsigned FP_EXP_WIDTH  = 8;
    localparam int unsigned FP_MANT_WIDTH = 23;
    localparam int unsigned FP_BIAS       = 2**(FP_EXP_WIDTH-1) - 1;
    localparam logic [FP_EXP_WIDTH-1:0] FP_EXP_MAX = '1;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_t;

    typedef struct packed {
        logic                   sign;
        fp_class_t              cls;
        logic [FP_EXP_WIDTH-1:0] exp;
        logic [FP_MANT_WIDTH:0]  significand;
    } fp_unpacked_t;

    // Denormals are flushed to zero, so an all-zero exponent always means ZERO.
    function automatic fp_class_t fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic mant_nz);
        if (exp_zero)
            return FP_ZERO;
        else if (exp_ones)
            return mant_nz ? FP_NAN : FP_INF;
        else
            return FP_NORM;
    endfunction

endpackage

// File: rtl/float_to_fixed_round_sat.sv
// Final stage: round-to-nearest-even, saturate to two's complement, register result.
module fixed_round_sat
    import fp_pkg::*;
#(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         i_en,
    input  logic         i_valid,
    input  logic         i_sign,
    input  fp_class_t    i_cls,
    input  logic         i_presat,
    input  logic [W-1:0] i_mag,
    input  logic         i_guard,
    input  logic         i_sticky,
    output logic         o_valid,
    output logic [W-1:0] o_q,
    output logic         o_ovf,
    output logic         o_nan
);

    localparam logic [W:0]   MAG_MAX_POS = {2'b00, {(W-1){1'b1}}};
    localparam logic [W:0]   MAG_MAX_NEG = {2'b01, {(W-1){1'b0}}};
    localparam logic [W-1:0] Q_MAX       = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] Q_MIN       = {1'b1, {(W-1){1'b0}}};

    logic         w_inc;
    logic [W:0]   w_mag_r;
    logic [W-1:0] w_q;
    logic         w_ovf;
    logic         w_nan;

    assign w_inc   = i_guard & (i_sticky | i_mag[0]);
    assign w_mag_r = {1'b0, i_mag} + {{W{1'b0}}, w_inc};

    // Range check uses the rounded magnitude, so a carry out of rounding saturates.
    always_comb begin
        w_q   = '0;
        w_ovf = 1'b0;
        w_nan = 1'b0;
        case (i_cls)
            FP_ZERO: w_q = '0;
            FP_NAN:  w_nan = 1'b1;
            FP_INF: begin
                w_q   = i_sign ? Q_MIN : Q_MAX;
                w_ovf = 1'b1;
            end
            default: begin
                if (i_presat) begin
                    w_q   = i_sign ? Q_MIN : Q_MAX;
                    w_ovf = 1'b1;
                end else if (!i_sign) begin
                    if (w_mag_r > MAG_MAX_POS) begin
                        w_q   = Q_MAX;
                        w_ovf = 1'b1;
                    end else begin
                        w_q = w_mag_r[W-1:0];
                    end
                end else begin
                    if (w_mag_r > MAG_MAX_NEG) begin
                        w_q   = Q_MIN;
                        w_ovf = 1'b1;
                    end else begin
                        w_q = -w_mag_r[W-1:0];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            o_valid <= 1'b0;
            o_q     <= '0;
            o_ovf   <= 1'b0;
            o_nan   <= 1'b0;
        end else if (i_en) begin
            o_valid <= i_valid;
            o_q     <= w_q;
            o_ovf   <= w_ovf;
            o_nan   <= w_nan;
        end
    end

endmodule

// File: rtl/float_to_fixed.sv
// Three-stage binary32 -> signed fixed-point converter with a single stall enable.
module float_to_fixed
    import fp_pkg::*;
#(
    parameter int unsigned FIXED_WIDTH = 12,
    parameter int unsigned EXP_WIDTH   = 8,
    parameter int unsigned MANT_WIDTH  = 23,
    parameter int unsigned FRAC_BITS   = 0
) (
    input  logic                           clk,
    input  logic                           areset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]  a,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [FIXED_WIDTH-1:0]         q,
    output logic                           ovf,
    output logic                           nan
);

    localparam int unsigned EW    = EXP_WIDTH + 2;
    localparam int unsigned ACC_W = FIXED_WIDTH + MANT_WIDTH + 1;
    localparam int          BIAS  = 2**(EXP_WIDTH-1) - 1;
    localparam int          E_OFF = int'(FRAC_BITS) - BIAS;
    localparam logic signed [EW-1:0] E_OFF_V = EW'(E_OFF);
    localparam logic signed [EW-1:0] E_SAT   = EW'(FIXED_WIDTH);
    localparam logic signed [EW-1:0] E_UNDER = EW'(-2);

    logic w_en;
    assign w_en     = ~(out_valid & ~out_ready);
    assign in_ready = w_en;

    logic [EXP_WIDTH-1:0]  w_exp;
    logic [MANT_WIDTH-1:0] w_mant;
    fp_class_t             w_cls;

    assign w_exp  = a[EXP_WIDTH+MANT_WIDTH-1:MANT_WIDTH];
    assign w_mant = a[MANT_WIDTH-1:0];
    assign w_cls  = fp_classify(w_exp == '0, w_exp == '1, w_mant != '0);

    logic                  r1_valid;
    logic                  r1_sign;
    fp_class_t             r1_cls;
    logic [EXP_WIDTH-1:0]  r1_exp;
    logic [MANT_WIDTH:0]   r1_sig;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_cls   <= FP_ZERO;
            r1_exp   <= '0;
            r1_sig   <= '0;
        end else if (w_en) begin
            r1_valid <= in_valid;
            r1_sign  <= a[EXP_WIDTH+MANT_WIDTH];
            r1_cls   <= w_cls;
            r1_exp   <= w_exp;
            r1_sig   <= {1'b1, w_mant};
        end
    end

    // Shifting by e+1 puts the binary point between bits MANT_WIDTH+1 and MANT_WIDTH
    // of the accumulator: integer part above, guard at MANT_WIDTH, sticky below.
    logic signed [EW-1:0]   w_e;
    logic [EW-1:0]          w_shamt;
    logic [ACC_W-1:0]       w_acc;
    logic                   w_presat;
    logic                   w_under;
    logic [FIXED_WIDTH-1:0] w_mag;
    logic                   w_guard;
    logic                   w_sticky;

    assign w_e      = $signed({2'b00, r1_exp}) + E_OFF_V;
    assign w_shamt  = w_e + EW'(1);
    assign w_acc    = {{FIXED_WIDTH{1'b0}}, r1_sig} << w_shamt;
    assign w_presat = (w_e >= E_SAT);
    assign w_under  = (w_e < E_UNDER);

    always_comb begin
        w_mag    = w_acc[ACC_W-1:MANT_WIDTH+1];
        w_guard  = w_acc[MANT_WIDTH];
        w_sticky = |w_acc[MANT_WIDTH-1:0];
        if (w_under) begin
            w_mag    = '0;
            w_guard  = 1'b0;
            w_sticky = 1'b1;
        end
    end

    logic                   r2_valid;
    logic                   r2_sign;
    fp_class_t              r2_cls;
    logic                   r2_presat;
    logic [FIXED_WIDTH-1:0] r2_mag;
    logic                   r2_guard;
    logic                   r2_sticky;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r2_valid  <= 1'b0;
            r2_sign   <= 1'b0;
            r2_cls    <= FP_ZERO;
            r2_presat <= 1'b0;
            r2_mag    <= '0;
            r2_guard  <= 1'b0;
            r2_sticky <= 1'b0;
        end else if (w_en) begin
            r2_valid  <= r1_valid;
            r2_sign   <= r1_sign;
            r2_cls    <= r1_cls;
            r2_presat <= w_presat;
            r2_mag    <= w_mag;
            r2_guard  <= w_guard;
            r2_sticky <= w_sticky;
        end
    end

    fixed_round_sat #(
        .W(FIXED_WIDTH)
    ) u_round_sat (
        .clk      (clk),
        .areset   (areset),
        .i_en     (w_en),
        .i_valid  (r2_valid),
        .i_sign   (r2_sign),
        .i_cls    (r2_cls),
        .i_presat (r2_presat),
        .i_mag    (r2_mag),
        .i_guard  (r2_guard),
        .i_sticky (r2_sticky),
        .o_valid  (out_valid),
        .o_q      (q),
        .o_ovf    (ovf),
        .o_nan    (nan)
    );

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed-vector bench for float_to_fixed (12-bit integer output).
module tb_float_to_fixed;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] q;
    logic        ovf;
    logic        nan;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    float_to_fixed #(
        .FIXED_WIDTH(12),
        .EXP_WIDTH  (8),
        .MANT_WIDTH (23),
        .FRAC_BITS  (0)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .ovf       (ovf),
        .nan       (nan)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [11:0] q;
        logic        ovf;
        logic        nan;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    endtask

    // One isolated sample: checks latency, result fields and a one-cycle out_valid pulse.
    task automatic apply(input vec_t v);
        int lat;
        @(negedge clk);
        a        = v.a;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({v.name, " latency"}, 32'(lat), 32'd3);
        check({v.name, " q"},   {20'd0, q},   {20'd0, v.q});
        check({v.name, " ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
        check({v.name, " nan"}, {31'd0, nan}, {31'd0, v.nan});
        @(negedge clk);
        check({v.name, " pulse"}, {31'd0, out_valid}, 32'd0);
    endtask

    logic [31:0] stream[8];
    int          rec[16];
    int          nrecv;
    int          sent;
    logic [11:0] q_hold;
    logic        seen;

    initial begin
        vecs[0]  = '{"pi",        32'h40490FDB, 12'h003, 1'b0, 1'b0};
        vecs[1]  = '{"2.5",       32'h40200000, 12'h002, 1'b0, 1'b0};
        vecs[2]  = '{"3.5",       32'h40600000, 12'h004, 1'b0, 1'b0};
        vecs[3]  = '{"0.5",       32'h3F000000, 12'h000, 1'b0, 1'b0};
        vecs[4]  = '{"0.75",      32'h3F400000, 12'h001, 1'b0, 1'b0};
        vecs[5]  = '{"-1.5",      32'hBFC00000, 12'hFFE, 1'b0, 1'b0};
        vecs[6]  = '{"-2048",     32'hC5000000, 12'h800, 1'b0, 1'b0};
        vecs[7]  = '{"2048",      32'h45000000, 12'h7FF, 1'b1, 1'b0};
        vecs[8]  = '{"2047.5",    32'h44FFF000, 12'h7FF, 1'b1, 1'b0};
        vecs[9]  = '{"-2049",     32'hC5001000, 12'h800, 1'b1, 1'b0};
        vecs[10] = '{"-2048.5",   32'hC5000800, 12'h800, 1'b0, 1'b0};
        vecs[11] = '{"2047",      32'h44FFE000, 12'h7FF, 1'b0, 1'b0};
        vecs[12] = '{"qnan",      32'h7FC00000, 12'h000, 1'b0, 1'b1};
        vecs[13] = '{"+inf",      32'h7F800000, 12'h7FF, 1'b1, 1'b0};
        vecs[14] = '{"-inf",      32'hFF800000, 12'h800, 1'b1, 1'b0};
        vecs[15] = '{"-0",        32'h80000000, 12'h000, 1'b0, 1'b0};
        vecs[16] = '{"denormal",  32'h00000001, 12'h000, 1'b0, 1'b0};
        vecs[17] = '{"-0.5",      32'hBF000000, 12'h000, 1'b0, 1'b0};

        stream[0] = 32'h3F800000; stream[1] = 32'h40000000;
        stream[2] = 32'h40400000; stream[3] = 32'h40800000;
        stream[4] = 32'h40A00000; stream[5] = 32'h40C00000;
        stream[6] = 32'h40E00000; stream[7] = 32'h41000000;

        // Reset state
        #12;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset q", {20'd0, q}, 32'd0);
        @(negedge clk);
        areset = 1'b0;
        #1;
        check("in_ready after reset", {31'd0, in_ready}, 32'd1);

        foreach (vecs[i]) apply(vecs[i]);

        // Back-to-back stream with a five-cycle output stall
        nrecv = 0;
        sent  = 0;
        q_hold = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c < 10);
            if (sent < 8) begin
                a        = stream[sent];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 5) q_hold = q;
            if (c >= 5 && c < 10) begin
                check("stall in_ready", {31'd0, in_ready}, 32'd0);
                check("stall out_valid", {31'd0, out_valid}, 32'd1);
                check("stall q stable", {20'd0, q}, {20'd0, q_hold});
            end
            if (out_valid && out_ready && nrecv < 16) begin
                rec[nrecv] = int'(q);
                nrecv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream count", 32'(nrecv), 32'd8);
        for (int i = 0; i < 8; i++)
            check("stream order", 32'(rec[i]), 32'(i + 1));

        // Asynchronous reset with three samples in flight
        @(negedge clk);
        a = 32'h7F800000; in_valid = 1'b1;
        @(negedge clk);
        a = 32'h7FC00000;
        @(negedge clk);
        a = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre-reset q", {20'd0, q}, 32'h7FF);
        #1;
        areset = 1'b1;
        #1;
        check("async reset out_valid", {31'd0, out_valid}, 32'd0);
        check("async reset q", {20'd0, q}, 32'd0);
        check("async reset ovf", {31'd0, ovf}, 32'd0);
        check("async reset nan", {31'd0, nan}, 32'd0);
        @(negedge clk);
        areset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no stale output", {31'd0, seen}, 32'd0);
        apply('{"post-reset 2.0", 32'h40000000, 12'h002, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
